// File: rtl/sao_bo_apply_if.sv
// Parameter, input-beat and output-beat signal bundle for the SAO band-offset apply block.
interface sao_bo_apply_if #(
    parameter int unsigned BIT_DEPTH = 8,
    parameter int unsigned N_PIX     = 4
);
    logic                            param_valid;
    logic                            param_ready;
    logic [1:0]                      param_cidx;
    logic                            param_bo_en;
    logic [4:0]                      param_band_pos;
    logic [3:0][5:0]                 param_offset;

    logic                            in_valid;
    logic                            in_ready;
    logic [N_PIX-1:0][BIT_DEPTH-1:0] in_pix;
    logic                            in_last;

    logic                            out_valid;
    logic                            out_ready;
    logic [N_PIX-1:0][BIT_DEPTH-1:0] out_pix;
    logic                            out_last;

    logic                            cnt_err;

    modport master (
        output param_valid, param_cidx, param_bo_en, param_band_pos, param_offset,
        input  param_ready,
        output in_valid, in_pix, in_last,
        input  in_ready,
        input  out_valid, out_pix, out_last, cnt_err,
        output out_ready
    );

    modport slave (
        input  param_valid, param_cidx, param_bo_en, param_band_pos, param_offset,
        output param_ready,
        input  in_valid, in_pix, in_last,
        output in_ready,
        output out_valid, out_pix, out_last, cnt_err,
        input  out_ready
    );
endinterface

// File: rtl/sao_bo_apply.sv
// Decoder-side SAO band offset: classifies each reconstructed sample into one of 32 bands
// and adds the signalled offset for the four bands starting at band_pos, with clipping.
module sao_bo_apply #(
    parameter int unsigned BIT_DEPTH = 8,
    parameter int unsigned N_PIX     = 4,
    parameter int unsigned CTB_LOG2  = 6
) (
    input logic           clk,
    input logic           arst,
    sao_bo_apply_if.slave bus
);
    localparam int unsigned OFF_W      = 6;
    localparam int unsigned SUM_W      = BIT_DEPTH + 2;
    localparam int unsigned CNT_W      = 2 * CTB_LOG2 + 1;
    localparam int unsigned EXP_LUMA   = (32'd1 << (2 * CTB_LOG2)) / N_PIX;
    localparam int unsigned EXP_CHROMA = EXP_LUMA / 4;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

    state_e state_q, state_d;
    logic   param_ready_c, in_ready_c, advance_c, in_fire_c, par_fire_c;

    logic [1:0]             cidx_q;
    logic                   bo_en_q;
    logic [4:0]             band_pos_q;
    logic [3:0][OFF_W-1:0]  offset_q;

    logic                                s1_valid_q, s1_last_q;
    logic [N_PIX-1:0][BIT_DEPTH-1:0]     s1_pix_q;
    logic [N_PIX-1:0]                    s1_hit_q;
    logic [N_PIX-1:0][OFF_W-1:0]         s1_off_q;
    logic [N_PIX-1:0]                    s1_hit_d;
    logic [N_PIX-1:0][OFF_W-1:0]         s1_off_d;
    logic [N_PIX-1:0][4:0]               band_k_c;

    logic                                s2_valid_q, out_last_q;
    logic [N_PIX-1:0][BIT_DEPTH-1:0]     out_pix_q, out_pix_d;
    logic [N_PIX-1:0][SUM_W-1:0]         sum_c;

    logic [CNT_W-1:0] cnt_q, cnt_nxt_c, exp_cnt_c;
    logic             cnt_err_q;

    assign advance_c  = !s2_valid_q || bus.out_ready;
    assign in_fire_c  = bus.in_valid && in_ready_c;
    assign par_fire_c = bus.param_valid && param_ready_c;

    // State register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (par_fire_c) state_d = RUN;
            RUN:     if (in_fire_c && bus.in_last) state_d = DRAIN;
            DRAIN:   if (!s1_valid_q && !s2_valid_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM handshake outputs; in_ready also waits on the pipeline having room
    always_comb begin
        param_ready_c = 1'b0;
        in_ready_c    = 1'b0;
        if (state_q == IDLE) param_ready_c = 1'b1;
        if (state_q == RUN)  in_ready_c    = advance_c;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cidx_q     <= '0;
            bo_en_q    <= 1'b0;
            band_pos_q <= '0;
            offset_q   <= '0;
        end else if (par_fire_c) begin
            cidx_q     <= bus.param_cidx;
            bo_en_q    <= bus.param_bo_en;
            band_pos_q <= bus.param_band_pos;
            offset_q   <= bus.param_offset;
        end
    end

    // Stage 1 classification: offset slot is the band distance from band_pos, mod 32
    always_comb begin
        band_k_c = '0;
        s1_hit_d = '0;
        s1_off_d = '0;
        for (int i = 0; i < int'(N_PIX); i++) begin
            band_k_c[i] = bus.in_pix[i][BIT_DEPTH-1 -: 5] - band_pos_q;
            s1_hit_d[i] = bo_en_q && (band_k_c[i][4:2] == 3'b000);
            s1_off_d[i] = offset_q[band_k_c[i][1:0]];
        end
    end

    // Stage 2 offset add with clip to [0, 2^BIT_DEPTH-1]
    always_comb begin
        sum_c     = '0;
        out_pix_d = s1_pix_q;
        for (int i = 0; i < int'(N_PIX); i++) begin
            sum_c[i] = {2'b00, s1_pix_q[i]}
                     + {{(SUM_W-OFF_W){s1_off_q[i][OFF_W-1]}}, s1_off_q[i]};
            if (s1_hit_q[i]) begin
                if (sum_c[i][SUM_W-1])                   out_pix_d[i] = '0;
                else if (sum_c[i][SUM_W-2 -: 1] != 1'b0) out_pix_d[i] = '1;
                else                                     out_pix_d[i] = sum_c[i][BIT_DEPTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_pix_q   <= '0;
            s1_hit_q   <= '0;
            s1_off_q   <= '0;
            s2_valid_q <= 1'b0;
            out_pix_q  <= '0;
            out_last_q <= 1'b0;
        end else if (advance_c) begin
            s1_valid_q <= in_fire_c;
            if (in_fire_c) begin
                s1_pix_q  <= bus.in_pix;
                s1_hit_q  <= s1_hit_d;
                s1_off_q  <= s1_off_d;
                s1_last_q <= bus.in_last;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_pix_q  <= out_pix_d;
                out_last_q <= s1_last_q;
            end
        end
    end

    assign cnt_nxt_c = cnt_q + CNT_W'(1);
    assign exp_cnt_c = (cidx_q == 2'd0) ? CNT_W'(EXP_LUMA) : CNT_W'(EXP_CHROMA);

    // Beat count check: the beat reaching the expected count must carry in_last and vice versa
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q     <= '0;
            cnt_err_q <= 1'b0;
        end else begin
            if (par_fire_c)     cnt_q <= '0;
            else if (in_fire_c) cnt_q <= cnt_nxt_c;
            if (in_fire_c) begin
                if (bus.in_last && (cnt_nxt_c != exp_cnt_c))  cnt_err_q <= 1'b1;
                if (!bus.in_last && (cnt_nxt_c >= exp_cnt_c)) cnt_err_q <= 1'b1;
            end
        end
    end

    assign bus.param_ready = param_ready_c;
    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = s2_valid_q;
    assign bus.out_pix     = out_pix_q;
    assign bus.out_last    = out_last_q;
    assign bus.cnt_err     = cnt_err_q;
endmodule

// File: doc/sao_bo_apply.md
Name: sao_bo_apply

Overview:
- Decoder-side counterpart of the encoder SAO band-offset statistics path; applies the signalled band offset to reconstructed samples of one component block per CTB.
- Accepts a per-block parameter set (band position, 4 offsets) through a handshake, then streams n_pix samples/beat through a 2-stage pipeline with band classification, offset add and clipping.
- Sits between the deblocking output stream and the SAO output buffer.

Parameters:
- bit_depth, 8, sample width; band index = pix >> (bit_depth-5).
- n_pix, 4, samples per beat.
- ctb_log2, 6, log2 luma CTB size; expected beats = 2^(2*ctb_log2)/n_pix for luma, a quarter of that for chroma (4:2:0).

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous reset, active-high.
- param_valid  in  1  parameter set offered.
- param_ready  out  1  block idle, accepts parameters.
- param_cidx  in  2  component: 0 = Y, 1 = Cb, 2 = Cr.
- param_bo_en  in  1  1 = apply BO; 0 = pass-through.
- param_band_pos  in  5  sao_band_position.
- param_offset[0:3]  in  6 each  signed offsets, already scaled to bit_depth.
- in_valid, in_ready  in/out  1  input beat handshake.
- in_pix[0:n_pix-1]  in  bit_depth each  input samples.
- in_last  in  1  final beat of the component block.
- out_valid, out_ready  out/in  1  output beat handshake.
- out_pix[0:n_pix-1]  out  bit_depth each  corrected samples.
- out_last  out  1  final output beat.
- cnt_err  out  1  sticky; in_last beat index did not match the expected beat count.

Behaviour:
- Reset (arst high, async): state IDLE; pipeline valid bits 0; out_valid 0, out_pix 0, out_last 0, cnt_err 0, beat counter 0, parameter registers 0. param_ready = 1 in IDLE.
- State machine:
  - IDLE -> RUN on param_valid && param_ready; capture all param_* fields.
  - RUN -> DRAIN on an accepted beat (in_valid && in_ready) with in_last.
  - DRAIN -> IDLE when both pipeline stages are empty, i.e. the out_last beat has been accepted.
  - param_ready = 1 only in IDLE. in_ready = 0 outside RUN.
- Pipeline: advance = !s2_valid || out_ready; s1 loads only when advance (no skid). in_ready = (state==RUN) && advance. Latency 2 cycles from input acceptance to out_valid with no backpressure; throughput 1 beat/cycle.
- Stage 1, per sample:
  - band = pix >> (bit_depth-5).
  - k = (band - band_pos) mod 32, 5-bit wrap.
  - hit = bo_en && k < 4.
  - Register pix, hit, and offset[k[1:0]].
- Stage 2, per sample: if hit, out = clip(pix + offset) to [0, 2^bit_depth - 1], computed in a bit_depth+2 signed intermediate; otherwise out = pix. out_last follows in_last down the pipeline.
- Band wrap: band_pos 29..31 wraps, e.g. band_pos = 30 maps bands 30, 31, 0, 1 to offset[0..3].
- Beat counter:
  - Increments on each accepted input beat.
  - On the in_last beat, compares count+1 with the expected count for the captured cidx; on mismatch, sets cnt_err (sticky until arst).
  - Clears to 0 on parameter capture.
  - An over-count without in_last (count wraps past expected) also sets cnt_err; the block keeps running until in_last.
- Simultaneous events: a parameter offer while in RUN/DRAIN waits (param_ready = 0). Output stalls hold out_pix/out_last stable while out_valid = 1.
- arst mid-block discards all in-flight beats; no output is produced after reset is released until a new parameter set is accepted.

Test Plan:
- bo_en = 0, luma, 1024 beats of ramp data, out_ready = 1 -> out_pix == in_pix, 2-cycle latency, out_last on beat 1024, cnt_err = 0, param_ready returns to 1.
- bo_en = 1, band_pos = 10, offsets {3, 0, 0, 0}, pix 85 -> 88; pix 95 (band 11, offset 0) -> 95; pix 79 (band 9, miss) -> 79.
- Wrap case: band_pos = 30, offsets {0, 7, -4, 0}: pix 5 (band 0) -> 1; pix 250 (band 31) -> 255 (clipped from 257); pix 247 (band 30, offset 0) -> 247.
- Clip low: band_pos = 0, offset[0] = -7, pix 3 -> 0; pix 7 -> 0. Clip high: band_pos = 28, offset[3] = 7, pix 255 -> 255.
- Backpressure: toggle out_ready randomly at 50% over a chroma block of 256 beats -> no lost or duplicated beats, out_pix held while stalled, in_ready low whenever s2 is full and out_ready is low.
- Chroma block with in_last on beat 200 -> cnt_err = 1 and stays set. Assert arst mid-luma-block -> out_valid = 0 immediately, param_ready = 1; the next block processes correctly.
